riscv_core_pipeline_control_t: RTL



---
 rtl/riscv_core_pipeline_control_t.sv | 106 ++++++++++
 1 files changed

// File: rtl/riscv_core_pipeline_control_t.sv
// riscv_core_pipeline_control_t: hazard/stall/flush controller for the 5-stage core, with deferred EX redirect and saturating perf counters
module riscv_core_pipeline_control_t #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ACT,
    input  logic              fe_busy,
    input  logic              id_hazard,
    input  logic              ex_busy,
    input  logic              me_busy,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_redirect_pc,
    input  logic              wb_trap,
    input  logic [ADDR_W-1:0] wb_trap_pc,
    output logic              fe_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              me_stall,
    output logic              id_clear,
    output logic              ex_clear,
    output logic              me_clear,
    output logic              wb_clear,
    output logic              fe_redirect,
    output logic [ADDR_W-1:0] fe_redirect_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic               live;
    always_comb begin
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;
        fe_stall       = 1'b1;
        id_stall       = 1'b1;
        ex_stall       = 1'b1;
        me_stall       = 1'b1;
        id_clear       = 1'b0;
        ex_clear       = 1'b0;
        me_clear       = 1'b0;
        wb_clear       = 1'b0;
        fe_redirect    = 1'b0;
        fe_redirect_pc = '0;
        live           = ACT && state_q != IDLE;
        if (!ACT) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = RUN;
        end else begin
            me_stall = me_busy;
            ex_stall = me_busy || ex_busy;
            id_stall = ex_stall || id_hazard;
            fe_stall = id_stall || fe_busy;
            wb_clear = me_busy;
            me_clear = !me_busy && ex_busy;
            ex_clear = !ex_stall && id_hazard;
            id_clear = !id_stall && fe_busy;
            if (wb_trap) begin
                {fe_stall, id_stall, ex_stall, me_stall} = 4'b0000;
                {id_clear, ex_clear, me_clear, wb_clear} = 4'b1111;
                fe_redirect    = 1'b1;
                fe_redirect_pc = wb_trap_pc;
                state_d        = RUN;
            end else if (!ex_stall && (state_q == PEND || ex_redirect)) begin
                // a held redirect takes precedence; a fresh one arriving in PEND is dropped
                fe_redirect    = 1'b1;
                fe_redirect_pc = state_q == PEND ? pend_pc_q : ex_redirect_pc;
                id_clear       = 1'b1;
                ex_clear       = 1'b1;
                fe_stall       = 1'b0;
                id_stall       = 1'b0;
                state_d        = RUN;
            end else if (state_q == RUN && ex_redirect) begin
                pend_pc_d = ex_redirect_pc;
                state_d   = PEND;
            end
        end
        stall_cnt_d = (live && fe_stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (fe_redirect && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        if (RST) begin
            {fe_stall, id_stall, ex_stall, me_stall} = 4'b1111;
            {id_clear, ex_clear, me_clear, wb_clear} = 4'b1111;
            fe_redirect    = 1'b0;
            fe_redirect_pc = '0;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            pend_pc_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule
